regfile_onehot_wb: RTL and testbench

//  Register file and write-back stage of the CPU datapath. Consumes the one-hot

---
 rtl/cpu_pkg.sv | 8 +
 rtl/onehot_chk.sv | 14 +
 rtl/regfile_onehot_wb.sv | 123 ++++++++++++
 tb/tb_regfile_onehot_wb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath parameters: default register-file geometry.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned NREGS_DEF  = 1 << ADDR_W_DEF;

endpackage

// File: rtl/onehot_chk.sv
// One-hot checker: is_onehot = 1 when exactly one bit of vec is set.
//   vec       in  N   vector under test
//   is_onehot out 1   combinational result
module onehot_chk #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] vec,
    output logic         is_onehot
);

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign is_onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/regfile_onehot_wb.sv
// Register file + write-back stage with one-hot write select, two registered
// read ports with write-through bypass, and a per-register busy scoreboard.
// R0 reads as zero and is never busy.
//   clk, rst             clock, async active-high reset
//   wr_en/wr_sel/wr_data write-back strobe, one-hot destination, data
//   rd_en                capture both read ports this cycle
//   rd_addr_a/b          binary read addresses
//   rd_data_a/b          registered read data (latency 1)
//   issue_en/issue_sel   issued instruction marks its one-hot destination busy
//   busy_a/b             comb busy flag of rd_addr_a/b
//   busy_vec             registered scoreboard, bit 0 always 0
//   sel_err              sticky flag for a non-one-hot select on an active strobe
module regfile_onehot_wb
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [(1 << ADDR_W)-1:0]  wr_sel,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic [DATA_W-1:0]         rd_data_a,
    output logic [DATA_W-1:0]         rd_data_b,
    input  logic                      issue_en,
    input  logic [(1 << ADDR_W)-1:0]  issue_sel,
    output logic                      busy_a,
    output logic                      busy_b,
    output logic [(1 << ADDR_W)-1:0]  busy_vec,
    output logic                      sel_err
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic              wr_ok;
    logic              iss_ok;
    logic              wr_legal;
    logic              iss_legal;
    logic [DATA_W-1:0] rd_next_a;
    logic [DATA_W-1:0] rd_next_b;
    logic [NREGS-1:0]  busy_next;
    logic [DATA_W-1:0] rf [1:NREGS-1];

    onehot_chk #(.N(NREGS)) u_wr_chk (
        .vec       (wr_sel),
        .is_onehot (wr_ok)
    );

    onehot_chk #(.N(NREGS)) u_iss_chk (
        .vec       (issue_sel),
        .is_onehot (iss_ok)
    );

    // An illegal select drops the whole write/issue.
    assign wr_legal  = wr_en & wr_ok;
    assign iss_legal = issue_en & iss_ok;

    // Read muxes with same-cycle write-through; address 0 falls through to 0.
    always_comb begin
        rd_next_a = '0;
        rd_next_b = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_next_a = (wr_legal && wr_sel[i]) ? wr_data : rf[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_next_b = (wr_legal && wr_sel[i]) ? wr_data : rf[i];
            end
        end
    end

    // Scoreboard: write clears, issue sets afterwards so a new producer wins.
    always_comb begin
        busy_next = busy_vec;
        if (wr_legal) begin
            busy_next = busy_next & ~wr_sel;
        end
        if (iss_legal) begin
            busy_next = busy_next | issue_sel;
        end
        busy_next[0] = 1'b0;
    end

    // Register array; a one-hot select to R0 matches no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr_legal && wr_sel[i]) begin
                    rf[i] <= wr_data;
                end
            end
        end
    end

    // Read ports, scoreboard and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            busy_vec  <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data_a <= rd_next_a;
                rd_data_b <= rd_next_b;
            end
            busy_vec <= busy_next;
            sel_err  <= sel_err | (wr_en & ~wr_ok) | (issue_en & ~iss_ok);
        end
    end

    assign busy_a = busy_vec[rd_addr_a];
    assign busy_b = busy_vec[rd_addr_b];

endmodule

// File: tb/tb_regfile_onehot_wb.sv
// Bench for regfile_onehot_wb: directed cases with literal expectations plus
// randomized legal traffic checked against a behavioural model every cycle.
module tb_regfile_onehot_wb;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_sel;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        issue_en;
    logic [15:0] issue_sel;
    logic        busy_a;
    logic        busy_b;
    logic [15:0] busy_vec;
    logic        sel_err;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    regfile_onehot_wb dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_vec  (busy_vec),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain array of register values and a busy set.
    logic [15:0] m_rf [16];
    logic [15:0] m_ra;
    logic [15:0] m_rb;
    bit          m_busy [16];
    bit          m_err;

    function automatic int first_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_rf[i]   = '0;
                m_busy[i] = 0;
            end
            m_ra  = '0;
            m_rb  = '0;
            m_err = 0;
        end else begin
            bit wok;
            bit iok;
            int widx;
            int iidx;
            wok  = wr_en && ($countones(wr_sel) == 1);
            iok  = issue_en && ($countones(issue_sel) == 1);
            widx = first_set(wr_sel);
            iidx = first_set(issue_sel);
            if (wr_en && !wok) m_err = 1;
            if (issue_en && !iok) m_err = 1;
            if (rd_en) begin
                if (rd_addr_a == 0) m_ra = '0;
                else if (wok && widx == int'(rd_addr_a)) m_ra = wr_data;
                else m_ra = m_rf[rd_addr_a];
                if (rd_addr_b == 0) m_rb = '0;
                else if (wok && widx == int'(rd_addr_b)) m_rb = wr_data;
                else m_rb = m_rf[rd_addr_b];
            end
            if (wok && widx != 0) begin
                m_rf[widx]   = wr_data;
                m_busy[widx] = 0;
            end
            if (iok && iidx != 0) m_busy[iidx] = 1;
        end
    end

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_data_a", 32'(rd_data_a), 32'(m_ra));
            chk("rd_data_b", 32'(rd_data_b), 32'(m_rb));
            chk("busy_vec",  32'(busy_vec),  32'(m_busy_vec()));
            chk("busy_a",    32'(busy_a),    32'(m_busy[rd_addr_a]));
            chk("busy_b",    32'(busy_b),    32'(m_busy[rd_addr_b]));
            chk("sel_err",   32'(sel_err),   32'(m_err));
        end
    end

    task automatic idle();
        wr_en     = 1'b0;
        wr_sel    = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        issue_en  = 1'b0;
        issue_sel = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("reset rd_data_a", 32'(rd_data_a), 32'h0);
        chk("reset busy_vec",  32'(busy_vec),  32'h0);
        chk("reset sel_err",   32'(sel_err),   32'h0);
        rst = 1'b0;
        chk_on = 1;

        // Write R3, read it back next cycle.
        idle(); wr_en = 1; wr_sel = 16'h0008; wr_data = 16'hBEEF;
        tick();
        idle(); rd_en = 1; rd_addr_a = 4'd3;
        tick();
        chk("read R3", 32'(rd_data_a), 32'hBEEF);

        // Bypass on port B, then R0 write/read stays zero.
        idle(); wr_en = 1; wr_sel = 16'h0020; wr_data = 16'h1234; rd_en = 1; rd_addr_b = 4'd5;
        tick();
        chk("bypass R5", 32'(rd_data_b), 32'h1234);
        idle(); wr_en = 1; wr_sel = 16'h0001; wr_data = 16'hFFFF; rd_en = 1; rd_addr_a = 4'd0;
        tick();
        chk("read R0", 32'(rd_data_a), 32'h0);

        // Scoreboard set, clear, and set-wins-over-clear.
        idle(); issue_en = 1; issue_sel = 16'h0040;
        tick();
        idle(); rd_addr_a = 4'd6;
        #1;
        chk("busy_vec R6 set", 32'(busy_vec), 32'h0040);
        chk("busy_a R6",       32'(busy_a),   32'h1);
        idle(); wr_en = 1; wr_sel = 16'h0040; wr_data = 16'h0606;
        tick();
        chk("busy R6 cleared", 32'(busy_vec), 32'h0);
        idle(); wr_en = 1; wr_sel = 16'h0040; wr_data = 16'h0607; issue_en = 1; issue_sel = 16'h0040;
        tick();
        chk("busy R6 reissued", 32'(busy_vec), 32'h0040);

        // Illegal selects: nothing changes, error sticks.
        idle(); wr_en = 1; wr_sel = 16'h0006; wr_data = 16'hAAAA;
        tick();
        chk("sel_err multi", 32'(sel_err), 32'h1);
        idle(); wr_en = 1; wr_sel = 16'h0000; wr_data = 16'h5555;
        tick();
        chk("sel_err held", 32'(sel_err), 32'h1);
        idle(); rd_en = 1; rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        tick();
        chk("R1 unchanged", 32'(rd_data_a), 32'h0);
        chk("R2 unchanged", 32'(rd_data_b), 32'h0);
        idle(); issue_en = 1; issue_sel = 16'h0300;
        tick();
        chk("busy after bad issue", 32'(busy_vec), 32'h0040);
        chk("sel_err still",        32'(sel_err),  32'h1);
        idle(); rd_en = 1; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
        tick();
        chk("R5 before reset", 32'(rd_data_a), 32'h1234);

        // Asynchronous reset mid-cycle clears everything at once.
        idle();
        #1 rst = 1'b1;
        #1;
        chk("async rst rd_data_a", 32'(rd_data_a), 32'h0);
        chk("async rst rd_data_b", 32'(rd_data_b), 32'h0);
        chk("async rst busy_vec",  32'(busy_vec),  32'h0);
        chk("async rst sel_err",   32'(sel_err),   32'h0);
        #2 rst = 1'b0;
        idle(); rd_en = 1; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
        tick();
        chk("R5 after reset", 32'(rd_data_a), 32'h0);
        chk("R3 after reset", 32'(rd_data_b), 32'h0);

        // Random legal traffic.
        for (int n = 0; n < 10000; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_sel    = 16'(1) << $urandom_range(0, 15);
            wr_data   = 16'($urandom);
            rd_en     = 1'($urandom_range(0, 3) != 0);
            rd_addr_a = 4'($urandom_range(0, 15));
            rd_addr_b = 4'($urandom_range(0, 15));
            issue_en  = 1'($urandom_range(0, 1));
            issue_sel = 16'(1) << $urandom_range(0, 15);
            tick();
        end

        idle();
        tick();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
